// File: rtl/mvau_inp_buf_ctrl_pkg.sv
// Shared constants and state encoding for the MVAU input buffer controller.
package mvau_inp_buf_ctrl_pkg;

  // Datapath geometry of the MVAU instance.
  localparam int unsigned TI       = 8;
  localparam int unsigned SIMD     = 4;
  localparam int unsigned PE       = 4;
  localparam int unsigned MATRIX_W = 64;
  localparam int unsigned MATRIX_H = 16;

  // Folding factors derived from the geometry.
  localparam int unsigned SF_DEF       = MATRIX_W / SIMD;
  localparam int unsigned NF_DEF       = MATRIX_H / PE;
  localparam int unsigned BUF_ADDR_DEF = $clog2(SF_DEF);
  localparam int unsigned NF_W_DEF     = $clog2(NF_DEF);

  // S_WRITE: first fold, input forwarded and stored; S_READ: replay folds.
  typedef enum logic {S_WRITE, S_READ} inp_ctrl_state_t;

endpackage

// File: rtl/mvau_inp_buf_ctrl_wrap_cnt.sv
// Enable-gated up-counter that wraps to zero after reaching MAX.
module mvau_wrap_cnt #(
  parameter int unsigned MAX = 15,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = (cnt_q == W'(MAX));
  assign cnt_o  = cnt_q;

  // Next count: advance on enable, wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer sequencer: stores each activation vector on its first
// fold while passing it through, then replays it for the remaining folds.
module mvau_inp_buf_ctrl
  import mvau_inp_buf_ctrl_pkg::*;
#(
  parameter int unsigned SF       = SF_DEF,
  parameter int unsigned NF       = NF_DEF,
  parameter int unsigned BUF_ADDR = BUF_ADDR_DEF,
  parameter int unsigned NF_W     = NF_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                out_v,
  output logic                inp_wr_en,
  output logic                inp_rd_en,
  output logic [BUF_ADDR-1:0] inp_addr,
  output logic                sf_first,
  output logic                sf_last,
  output logic [NF_W-1:0]     nf_idx
);

  inp_ctrl_state_t     state_q;
  inp_ctrl_state_t     state_d;
  logic                fire_c;
  logic                nf_en_c;
  logic [BUF_ADDR-1:0] sf_cnt;
  logic                sf_wrap;
  logic [NF_W-1:0]     nf_cnt;
  logic                nf_wrap;

  // Beat index within the current fold; doubles as the buffer address.
  mvau_wrap_cnt #(
    .MAX (SF - 1),
    .W   (BUF_ADDR)
  ) u_sf_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (fire_c),
    .cnt_o  (sf_cnt),
    .wrap_o (sf_wrap)
  );

  // Fold index; advances once per completed fold.
  mvau_wrap_cnt #(
    .MAX (NF - 1),
    .W   (NF_W)
  ) u_nf_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (nf_en_c),
    .cnt_o  (nf_cnt),
    .wrap_o (nf_wrap)
  );

  // State register with synchronous reset back to the write pass.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_WRITE;
    else        state_q <= state_d;
  end

  // Handshake, buffer control, framing strobes and next state.
  always_comb begin
    state_d   = state_q;
    in_rdy    = 1'b0;
    out_v     = 1'b0;
    inp_wr_en = 1'b0;
    inp_rd_en = 1'b0;
    inp_addr  = sf_cnt;
    nf_idx    = nf_cnt;

    case (state_q)
      S_WRITE: begin
        in_rdy    = out_rdy;
        out_v     = in_v;
        inp_wr_en = in_v & out_rdy;
      end
      S_READ: begin
        inp_rd_en = 1'b1;
        out_v     = 1'b1;
      end
      default: ;
    endcase

    fire_c   = out_v & out_rdy;
    nf_en_c  = fire_c & sf_wrap;
    sf_first = out_v & (sf_cnt == '0);
    sf_last  = out_v & sf_wrap;

    if (nf_en_c) begin
      state_d = nf_wrap ? S_WRITE : S_READ;
    end
  end

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Bench for mvau_inp_buf_ctrl: SF=4/NF=3 instance with a buffer model and
// a beat scoreboard, plus an SF=1/NF=1 pass-through instance.
module tb_mvau_inp_buf_ctrl;

  localparam int unsigned SF_A = 4;
  localparam int unsigned NF_A = 3;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A (SF=4, NF=3)
  logic       rst_a, in_v_a, out_rdy_a;
  logic [7:0] in_data_a;
  logic       in_rdy_a, out_v_a, wr_a, rd_a, first_a, last_a;
  logic [3:0] addr_a;
  logic [1:0] nf_a;

  mvau_inp_buf_ctrl #(.SF(SF_A), .NF(NF_A), .BUF_ADDR(4), .NF_W(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .in_v(in_v_a), .in_rdy(in_rdy_a),
    .out_rdy(out_rdy_a), .out_v(out_v_a), .inp_wr_en(wr_a), .inp_rd_en(rd_a),
    .inp_addr(addr_a), .sf_first(first_a), .sf_last(last_a), .nf_idx(nf_a)
  );

  // Instance B (SF=1, NF=1)
  logic       rst_b, in_v_b, out_rdy_b;
  logic       in_rdy_b, out_v_b, wr_b, rd_b, first_b, last_b;
  logic [0:0] addr_b;
  logic [0:0] nf_b;

  mvau_inp_buf_ctrl #(.SF(1), .NF(1), .BUF_ADDR(1), .NF_W(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .in_v(in_v_b), .in_rdy(in_rdy_b),
    .out_rdy(out_rdy_b), .out_v(out_v_b), .inp_wr_en(wr_b), .inp_rd_en(rd_b),
    .inp_addr(addr_b), .sf_first(first_b), .sf_last(last_b), .nf_idx(nf_b)
  );

  // Buffer model: synchronous write, combinational read, pass-through when rd=0.
  logic [7:0] mem_a [0:15];
  logic [7:0] buf_out_a;
  always @(posedge clk) if (wr_a) mem_a[addr_a] <= in_data_a;
  assign buf_out_a = rd_a ? mem_a[addr_a] : in_data_a;

  typedef struct {
    logic [7:0] data;
    logic [3:0] addr;
    logic [1:0] nf;
    logic       first;
    logic       last;
    logic       rd;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic       in_v;
    logic       out_rdy;
    logic [7:0] data;
    logic       e_in_rdy;
    logic       e_out_v;
    logic       e_wr;
    logic       e_rd;
    logic [3:0] e_addr;
    logic [1:0] e_nf;
    logic       e_first;
    logic       e_last;
  } vec_t;
  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats of one vector: stored data replayed over all folds.
  task automatic push_vector(input logic [7:0] base);
    for (int f = 0; f < int'(NF_A); f++)
      for (int s = 0; s < int'(SF_A); s++) begin
        beat_t b;
        b.data  = base + 8'(s);
        b.addr  = 4'(s);
        b.nf    = 2'(f);
        b.first = (s == 0);
        b.last  = (s == int'(SF_A) - 1);
        b.rd    = (f != 0);
        sb.push_back(b);
      end
  endtask

  // One cycle on instance A; every fire is checked against the scoreboard.
  task automatic drive_a(input logic r, input logic v, input logic rdy, input logic [7:0] d);
    beat_t b;
    @(negedge clk);
    rst_a = r; in_v_a = v; out_rdy_a = rdy; in_data_a = d;
    #1;
    if (out_v_a && out_rdy_a) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_fire", 32'd1, 32'd0);
      end else begin
        b = sb.pop_front();
        chk("sb_data",  32'(buf_out_a), 32'(b.data));
        chk("sb_addr",  32'(addr_a),    32'(b.addr));
        chk("sb_nf",    32'(nf_a),      32'(b.nf));
        chk("sb_first", 32'(first_a),   32'(b.first));
        chk("sb_last",  32'(last_a),    32'(b.last));
        chk("sb_rd",    32'(rd_a),      32'(b.rd));
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 1'b0};

    rst_a = 1'b0; in_v_a = 1'b0; out_rdy_a = 1'b1; in_data_a = 8'h00;
    rst_b = 1'b0; in_v_b = 1'b0; out_rdy_b = 1'b1;

    // Reset state of instance A
    drive_a(1'b0, 1'b0, 1'b1, 8'h00);
    drive_a(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rst_in_rdy", 32'(in_rdy_a), 32'd1);
    chk("rst_out_v",  32'(out_v_a),  32'd0);
    chk("rst_rd",     32'(rd_a),     32'd0);
    chk("rst_addr",   32'(addr_a),   32'd0);
    chk("rst_nf",     32'(nf_a),     32'd0);

    // Continuous flow: vector A fully, then first beat of vector B
    push_vector(8'hA0);
    push_vector(8'hB0);
    for (int i = 0; i < 13; i++) begin
      drive_a(1'b1, tbl[i].in_v, tbl[i].out_rdy, tbl[i].data);
      chk($sformatf("tbl%0d_in_rdy", i), 32'(in_rdy_a), 32'(tbl[i].e_in_rdy));
      chk($sformatf("tbl%0d_out_v", i),  32'(out_v_a),  32'(tbl[i].e_out_v));
      chk($sformatf("tbl%0d_wr", i),     32'(wr_a),     32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_rd", i),     32'(rd_a),     32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_addr", i),   32'(addr_a),   32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_nf", i),     32'(nf_a),     32'(tbl[i].e_nf));
      chk($sformatf("tbl%0d_first", i),  32'(first_a),  32'(tbl[i].e_first));
      chk($sformatf("tbl%0d_last", i),   32'(last_a),   32'(tbl[i].e_last));
    end

    // Rest of vector B's write pass
    for (int s = 1; s < 4; s++) begin
      drive_a(1'b1, 1'b1, 1'b1, 8'hB0 + 8'(s));
      chk("b_wr", 32'(wr_a), 32'd1);
    end

    // Fold 1 addr 0,1 then a 3-cycle stall at addr 2
    drive_a(1'b1, 1'b1, 1'b1, 8'hC0);
    drive_a(1'b1, 1'b1, 1'b1, 8'hC0);
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 1'b1, 1'b0, 8'hC0);
      chk("stall_addr",   32'(addr_a),   32'd2);
      chk("stall_nf",     32'(nf_a),     32'd1);
      chk("stall_wr",     32'(wr_a),     32'd0);
      chk("stall_in_rdy", 32'(in_rdy_a), 32'd0);
    end
    chk("stall_sb_left", 32'(sb.size()), 32'd6);

    // Resume; upstream holds C0 while replay finishes
    for (int k = 0; k < 6; k++) begin
      drive_a(1'b1, 1'b1, 1'b1, 8'hC0);
      chk("read_in_rdy", 32'(in_rdy_a), 32'd0);
      chk("read_wr",     32'(wr_a),     32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Vector C accepted right after the final replay beat
    push_vector(8'hC0);
    drive_a(1'b1, 1'b1, 1'b1, 8'hC0);
    chk("c0_in_rdy", 32'(in_rdy_a), 32'd1);
    chk("c0_wr",     32'(wr_a),     32'd1);
    chk("c0_addr",   32'(addr_a),   32'd0);
    chk("c0_nf",     32'(nf_a),     32'd0);
    for (int s = 1; s < 4; s++) drive_a(1'b1, 1'b1, 1'b1, 8'hC0 + 8'(s));
    drive_a(1'b1, 1'b1, 1'b1, 8'hD0);

    // Reset asserted at fold 1 addr 1
    drive_a(1'b0, 1'b1, 1'b1, 8'hD0);
    chk("prerst_addr", 32'(addr_a), 32'd1);
    chk("prerst_nf",   32'(nf_a),   32'd1);
    sb.delete();
    drive_a(1'b1, 1'b0, 1'b1, 8'hD0);
    chk("postrst_addr",   32'(addr_a),   32'd0);
    chk("postrst_nf",     32'(nf_a),     32'd0);
    chk("postrst_rd",     32'(rd_a),     32'd0);
    chk("postrst_in_rdy", 32'(in_rdy_a), 32'd1);
    chk("postrst_out_v",  32'(out_v_a),  32'd0);

    // Instance B: SF=1, NF=1 pure pass-through
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] pat;
      pat = 4'(i);
      @(negedge clk);
      in_v_b = pat[0]; out_rdy_b = pat[1] | pat[2];
      #1;
      chk("b_in_rdy", 32'(in_rdy_b), 32'(out_rdy_b));
      chk("b_out_v",  32'(out_v_b),  32'(in_v_b));
      chk("b_wr",     32'(wr_b),     32'(in_v_b & out_rdy_b));
      chk("b_rd",     32'(rd_b),     32'd0);
      chk("b_first",  32'(first_b),  32'(in_v_b));
      chk("b_last",   32'(last_b),   32'(in_v_b));
      chk("b_addr",   32'(addr_b),   32'd0);
      chk("b_nf",     32'(nf_b),     32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mvau_inp_buf_ctrl.md
Name: mvau_inp_buf_ctrl

Overview:
- Sequencing controller for the MVAU stream input buffer.
- Accepts one activation vector (SF beats of TI bits each) from the upstream stream, writes it into the buffer, and passes it through to the compute lane in the same pass.
- Replays the vector from the buffer NF-1 more times, once per remaining PE-row fold.
- Drives the buffer's wr_en/rd_en/addr and generates valid, ready and accumulation-framing strobes for the PE array.

Parameters:
- SF, 16: MatrixW/SIMD; buffer depth and beats per vector.
- NF, 4: MatrixH/PE; number of passes over each stored vector.
- BUF_ADDR, 4: address width, >= clog2(SF).
- NF_W, 2: nf counter width, >= clog2(NF).

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous active-low reset
- in_v  in  1  upstream activation beat valid
- in_rdy  out  1  controller can accept an upstream beat
- out_rdy  in  1  compute lane / weight stream ready to consume a beat
- out_v  out  1  buffer output beat valid toward the compute lane
- inp_wr_en  out  1  buffer write enable
- inp_rd_en  out  1  buffer read enable (0 selects pass-through)
- inp_addr  out  BUF_ADDR  buffer address (shared for read and write)
- sf_first  out  1  current beat is sf index 0 (clear accumulator)
- sf_last  out  1  current beat is sf index SF-1 (accumulator result valid)
- nf_idx  out  NF_W  current fold index

Behaviour:
- Reset (rst_n=0 sampled at the clk edge):
  - state=S_WRITE; sf_cnt=0; nf_cnt=0.
  - Outputs follow combinationally: in_rdy=out_rdy, out_v=in_v, inp_rd_en=0, inp_addr=0, nf_idx=0.
  - Reset mid-vector discards the partial vector; buffer contents are not cleared.
- State S_WRITE (first pass, nf_cnt=0):
  - in_rdy=out_rdy; out_v=in_v.
  - inp_wr_en=in_v&out_rdy; inp_rd_en=0, so the buffer output forwards the input.
- State S_READ (replay passes, nf_cnt 1..NF-1):
  - in_rdy=0; inp_wr_en=0; inp_rd_en=1; out_v=1.
  - The buffer read is combinational, so data is valid in the same cycle as the address.
- Common to both states:
  - inp_addr=sf_cnt; nf_idx=nf_cnt.
  - sf_first=out_v&(sf_cnt==0); sf_last=out_v&(sf_cnt==SF-1).
- Beat fire: fire=out_v&out_rdy. State and counters change only on fire.
- On fire:
  - If sf_cnt==SF-1: sf_cnt wraps to 0 and the fold ends. Otherwise sf_cnt increments.
  - Fold end with nf_cnt==NF-1: nf_cnt returns to 0 and the next state is S_WRITE.
  - Fold end otherwise: nf_cnt increments and the next state is S_READ.
- Latency:
  - Zero-cycle pass-through in S_WRITE.
  - Exactly NF*SF fires per vector; with out_rdy held at 1, a vector takes NF*SF cycles.
  - The next vector is accepted in the cycle after the final replay beat; there are no bubbles.
- Stall: out_rdy=0 freezes all counters and state. inp_addr holds and no write occurs.
- Simultaneous in_v in S_READ: ignored (in_rdy=0); upstream holds its data.
- NF=1: S_READ is never entered; the controller acts as a pure pass-through that still writes the buffer.
- SF=1: sf_first and sf_last are both asserted on every fire.
- Width rules: counters compare against SF-1 and NF-1 exactly. Unused address codes (>=SF) are never produced.

Decomposition:
- mvau_defn.sv package holds:
  - typedef enum logic {S_WRITE, S_READ} inp_ctrl_state_t;
  - the existing TI/SIMD/PE constants; SF and NF derived constants are added there.
- Sub-module mvau_wrap_cnt #(MAX, W): an enable-gated counter with wrap flag, instantiated twice (sf, nf).
- All remaining logic is in a single always_ff and a single always_comb.

Test Plan:
- Reset, then SF=4, NF=3 with in_v=1 and out_rdy=1 continuously. Required response:
  - 12 out_v fires per vector.
  - inp_addr sequence 0,1,2,3 repeated 3 times.
  - inp_wr_en high only in cycles 0-3; inp_rd_en high in cycles 4-11.
  - in_rdy high again in cycle 12.
- Write pass data D0..D3 = 0xA0..0xA3. Required: replay output beats are 0xA0..0xA3 in both folds 1 and 2, and sf_first/sf_last pulse at addr 0/3 in each fold.
- out_rdy=0 for 3 cycles at addr 2 of fold 1. Required: inp_addr holds at 2, nf_idx holds at 1, no extra fires, and the sequence resumes correctly.
- in_v=1 throughout S_READ. Required: in_rdy=0 and inp_wr_en=0; the next vector's first beat is accepted only after fold 2 beat 3.
- rst_n=0 at fold 1 addr 1. Required: the next cycle shows S_WRITE, inp_addr=0, nf_idx=0, inp_rd_en=0.
- NF=1, SF=1 build. Required: every accepted beat has inp_wr_en=1, sf_first=sf_last=1 and inp_rd_en=0.
